mux: RTL and testbench

// - Parameterised N:1 single-bit multiplexer with a registered output.
// - Selects one bit of a MUX_WIDTH-bit bus using a binary select.
// - Select path is built as a balanced tree of gate-level 2:1 cells with modelled gate delay.
// - Generic building block for the OoO core datapath: operand/bypass select, bit-slice muxing.

---
 rtl/mux_pkg.sv | 16 +
 rtl/mux_if.sv | 35 +++
 rtl/mux_mux2_1.sv | 32 +++
 rtl/mux.sv | 83 ++++++++
 tb/tb_mux.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared helper for the bit-select multiplexer family. Anything that sizes a
// select bus for a given number of data inputs calls sel_width(), so the
// interface and the mux body can never disagree on the select width.
// -----------------------------------------------------------------------------
package mux_pkg;

  // Number of binary select bits needed to address n data inputs.
  // Degenerate widths (n < 2) still return 1 so that declarations stay legal
  // long enough for the width check in the mux body to report the real error.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : mux_pkg

// File: rtl/mux_if.sv
// -----------------------------------------------------------------------------
// mux_if
// Bundle of the data, select and result signals of one bit-select mux.
//   in   [MUX_WIDTH-1:0]  data choices, bit i chosen when sel == i
//   sel  [SEL_W-1:0]      binary select, SEL_W = sel_width(MUX_WIDTH)
//   out                   registered selected bit
// Modports:
//   master  - the parent that drives data/select and consumes the result
//   slave   - the mux itself
// -----------------------------------------------------------------------------
interface mux_if
  import mux_pkg::*;
#(
  parameter int MUX_WIDTH = 16
);

  localparam int SEL_W = sel_width(MUX_WIDTH);

  logic [MUX_WIDTH-1:0] in;
  logic [SEL_W-1:0]     sel;
  logic                 out;

  modport master (
    output in,
    output sel,
    input  out
  );

  modport slave (
    input  in,
    input  sel,
    output out
  );

endinterface : mux_if

// File: rtl/mux_mux2_1.sv
// -----------------------------------------------------------------------------
// mux2_1
// Gate-level 2:1 cell used as the leaf of the select tree.
//   a  data chosen when s = 0
//   b  data chosen when s = 1
//   s  select
//   y  (a & ~s) | (b & s)
// Every primitive carries GATE_DELAY so the tree settle time can be observed
// in simulation. Worst-case path through one cell is NOT -> AND -> OR, i.e.
// 3 * GATE_DELAY. The delays have no effect on synthesis.
// A don't-care on the unselected leg is masked by the AND gate whose other
// input is 0, so it never reaches y once the cell has settled.
// -----------------------------------------------------------------------------
module mux2_1 #(
  parameter int GATE_DELAY = 50
) (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  logic s_n;
  logic a_term;
  logic b_term;

  not #(GATE_DELAY) u_not_s  (s_n,    s);
  and #(GATE_DELAY) u_and_a  (a_term, a, s_n);
  and #(GATE_DELAY) u_and_b  (b_term, b, s);
  or  #(GATE_DELAY) u_or_y   (y,      a_term, b_term);

endmodule : mux2_1

// File: rtl/mux.sv
// -----------------------------------------------------------------------------
// mux
// Parameterised N:1 single-bit multiplexer with a registered output.
// Generic datapath building block (operand / bypass select, bit-slice muxing).
//
// Parameters:
//   MUX_WIDTH   number of data inputs; power of two, >= 2
//   GATE_DELAY  delay of every primitive gate in the select tree
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears out immediately
//   bus    mux_if slave: in / sel inputs, out registered result
//
// Behaviour:
//   out <= in[sel] on every rising clk edge (1-cycle latency, no enable).
//   The combinational result settles within sel_width(MUX_WIDTH) * 3 *
//   GATE_DELAY; the clock period must exceed that, and it is not checked.
//
// Select tree layout:
//   All tree nodes live in one flat vector, level after level. Level 0 is the
//   data bus itself (MUX_WIDTH nodes); level k holds MUX_WIDTH >> k nodes and
//   starts at offset 2*MUX_WIDTH - 2*(MUX_WIDTH >> k). The root therefore sits
//   at index 2*MUX_WIDTH - 2. Level k cells are all steered by sel[k] and pair
//   node 2j (a, chosen on 0) with node 2j+1 (b, chosen on 1), so the LSB of
//   sel decides between neighbouring inputs and the MSB decides last.
// -----------------------------------------------------------------------------
module mux
  import mux_pkg::*;
#(
  parameter int MUX_WIDTH  = 16,
  parameter int GATE_DELAY = 50
) (
  input  logic    clk,
  input  logic    rst_n,
  mux_if.slave    bus
);

  localparam int SEL_W  = sel_width(MUX_WIDTH);
  localparam int LEVELS = SEL_W;
  localparam int NODES  = 2 * MUX_WIDTH - 1;
  localparam int ROOT   = NODES - 1;

  // Refuse to build anything that is not a full binary tree.
  if ((MUX_WIDTH < 2) || ((MUX_WIDTH & (MUX_WIDTH - 1)) != 0)) begin : g_bad_width
    $fatal(1, "mux: MUX_WIDTH=%0d must be a power of two and >= 2", MUX_WIDTH);
  end

  logic [NODES-1:0] node;
  logic             sel_d;

  assign node[MUX_WIDTH-1:0] = bus.in;

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_OFF  = 2 * MUX_WIDTH - 2 * (MUX_WIDTH >> k);
    localparam int OUT_OFF = 2 * MUX_WIDTH - 2 * (MUX_WIDTH >> (k + 1));
    localparam int CELLS   = MUX_WIDTH >> (k + 1);

    for (genvar j = 0; j < CELLS; j++) begin : g_cell
      mux2_1 #(
        .GATE_DELAY (GATE_DELAY)
      ) u_cell (
        .a (node[IN_OFF + 2*j]),
        .b (node[IN_OFF + 2*j + 1]),
        .s (bus.sel[k]),
        .y (node[OUT_OFF + j])
      );
    end
  end

  assign sel_d = node[ROOT];

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its inputs; blocking here would create ordering races.
  // The asynchronous clear wins over a clock edge landing in the same timestep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out <= 1'b0;
    end else begin
      bus.out <= sel_d;
    end
  end

endmodule : mux

// File: tb/tb_mux.sv
// -----------------------------------------------------------------------------
// tb_mux
// Self-checking bench for mux at MUX_WIDTH = 16, 2 and 64. Expected values are
// pushed to a scoreboard queue when stimulus is applied and popped when the
// registered output is sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mux;

  localparam int GATE_DELAY = 50;
  // Worst settle is 6 levels * 3 gates * 50 = 900 for the 64-input instance;
  // a 5000 period keeps every instance at >= 5x its settle time.
  localparam int HALF = 2500;

  typedef struct {
    string tag;
    logic  exp;
  } sb_t;

  logic clk;
  logic rst_n;
  logic [5:0] wide_sel;

  sb_t sb_q[$];
  int  tests_run;
  int  tests_failed;

  mux_if #(.MUX_WIDTH(16)) bus16 ();
  mux_if #(.MUX_WIDTH(2))  bus2  ();
  mux_if #(.MUX_WIDTH(64)) bus64 ();

  mux #(.MUX_WIDTH(16), .GATE_DELAY(GATE_DELAY)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  mux #(.MUX_WIDTH(2), .GATE_DELAY(GATE_DELAY)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  mux #(.MUX_WIDTH(64), .GATE_DELAY(GATE_DELAY)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  initial begin
    clk = 1'b0;
    forever #(HALF) clk = ~clk;
  end

  task automatic check(input string tag, input logic actual, input logic expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", tag, actual, expected);
    end
  endtask

  task automatic sb_compare(input logic actual);
    sb_t e;
    e = sb_q.pop_front();
    check(e.tag, actual, e.exp);
  endtask

  // Each apply task is entered on a falling edge, drives the inputs, records
  // the expectation, waits one full cycle and compares the registered result.
  task automatic apply16(input logic [15:0] i, input logic [3:0] s,
                         input logic exp, input string tag);
    bus16.in  = i;
    bus16.sel = s;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    sb_compare(bus16.out);
  endtask

  task automatic apply2(input logic [1:0] i, input logic s,
                        input logic exp, input string tag);
    bus2.in  = i;
    bus2.sel = s;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    sb_compare(bus2.out);
  endtask

  task automatic apply64(input logic [63:0] i, input logic [5:0] s,
                         input logic exp, input string tag);
    bus64.in  = i;
    bus64.sel = s;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    sb_compare(bus64.out);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    bus16.in = '0;  bus16.sel = '0;
    bus2.in  = '0;  bus2.sel  = '0;
    bus64.in = '0;  bus64.sel = '0;

    // Power-on reset, asserted away from any clock edge.
    #10 rst_n = 1'b0;
    #1;
    check("por_out16", bus16.out, 1'b0);
    check("por_out2",  bus2.out,  1'b0);
    check("por_out64", bus64.out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table from the F0F0 pattern.
    apply16(16'hF0F0, 4'd15, 1'b1, "f0f0_sel15");

    // Reset mid-cycle with out = 1 and a selected input of 1.
    #500 rst_n = 1'b0;
    #1 check("rst_async_clear", bus16.out, 1'b0);
    @(negedge clk);
    check("rst_held_over_edge", bus16.out, 1'b0);
    rst_n = 1'b1;
    #1 check("rst_release", bus16.out, 1'b0);
    #1000 check("rst_release_pre_edge", bus16.out, 1'b0);
    @(negedge clk);
    check("rst_first_edge", bus16.out, 1'b1);

    apply16(16'hF0F0, 4'd8,  1'b0, "f0f0_sel8");
    apply16(16'hF0F0, 4'd0,  1'b0, "f0f0_sel0");
    apply16(16'hF0F0, 4'd4,  1'b1, "f0f0_sel4");

    apply16(16'h0001, 4'd0,  1'b1, "0001_sel0");
    apply16(16'h0001, 4'd8,  1'b0, "0001_sel8");
    apply16(16'h0001, 4'd15, 1'b0, "0001_sel15");

    apply16(16'h0002, 4'd1,  1'b1, "0002_sel1");
    apply16(16'h0002, 4'd0,  1'b0, "0002_sel0");
    apply16(16'h0003, 4'd0,  1'b1, "0003_sel0");
    apply16(16'h0003, 4'd1,  1'b1, "0003_sel1");

    // Single set bit at position 12: only sel = 12 returns 1.
    for (int s = 0; s < 16; s++) begin
      apply16(16'h1000, 4'(s), (s == 12) ? 1'b1 : 1'b0,
              $sformatf("1000_sel%0d", s));
    end

    // The parent truncates a wider select; 63 lands on 15.
    wide_sel = 6'd63;
    apply16(16'h1000, wide_sel[3:0], 1'b0, "1000_sel63_trunc");

    // Walking one with sel in step, then sel offset by one.
    for (int i = 0; i < 16; i++) begin
      apply16(16'd1 << i, 4'(i), 1'b1, $sformatf("walk16_%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      apply16(16'd1 << i, 4'(i + 1), 1'b0, $sformatf("walk16_off_%0d", i));
    end

    for (int i = 0; i < 2; i++) begin
      apply2(2'd1 << i, 1'(i), 1'b1, $sformatf("walk2_%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      apply2(2'd1 << i, 1'(i + 1), 1'b0, $sformatf("walk2_off_%0d", i));
    end

    for (int i = 0; i < 64; i++) begin
      apply64(64'd1 << i, 6'(i), 1'b1, $sformatf("walk64_%0d", i));
    end
    for (int i = 0; i < 64; i++) begin
      apply64(64'd1 << i, 6'(i + 1), 1'b0, $sformatf("walk64_off_%0d", i));
    end

    check("sb_drained", (sb_q.size() == 0) ? 1'b1 : 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_mux
